// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter and its serializer.
package uart_arb_pkg;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    // Clock cycles per UART bit, truncated toward zero.
    function automatic int calc_divisor(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART serializer: one byte per frame, each bit held DIVISOR cycles, ready during the last stop cycle.
module uart_tx
    import uart_arb_pkg::*;
#(
    parameter int DIVISOR = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       tx
);

    localparam int             TW        = $clog2(DIVISOR);
    localparam logic [TW-1:0]  TIMER_MAX = TW'(DIVISOR - 1);
    localparam logic [3:0]     STOP_IDX  = 4'(FRAME_BITS - 1);
    localparam logic [3:0]     DATA_END  = 4'(DATA_BITS);

    logic          active_r;
    logic [3:0]    bit_cnt_r;
    logic [TW-1:0] timer_r;
    logic [7:0]    shift_r;
    logic          tx_r;
    logic          bit_end_s;
    logic          accept_s;

    assign bit_end_s = active_r && (timer_r == TIMER_MAX);
    assign in_ready  = !active_r || (bit_end_s && (bit_cnt_r == STOP_IDX));
    assign accept_s  = in_valid && in_ready;
    assign tx        = tx_r;

    // Frame sequencing: start bit, eight data bits LSB first, stop bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            active_r  <= 1'b0;
            bit_cnt_r <= 4'd0;
            timer_r   <= '0;
            shift_r   <= 8'd0;
            tx_r      <= 1'b1;
        end else if (accept_s) begin
            active_r  <= 1'b1;
            bit_cnt_r <= 4'd0;
            timer_r   <= '0;
            shift_r   <= in_data;
            tx_r      <= 1'b0;
        end else if (active_r) begin
            if (bit_end_s) begin
                timer_r <= '0;
                if (bit_cnt_r == STOP_IDX) begin
                    active_r  <= 1'b0;
                    bit_cnt_r <= 4'd0;
                    tx_r      <= 1'b1;
                end else begin
                    bit_cnt_r <= bit_cnt_r + 4'd1;
                    if (bit_cnt_r < DATA_END) begin
                        tx_r    <= shift_r[0];
                        shift_r <= {1'b0, shift_r[7:1]};
                    end else begin
                        tx_r <= 1'b1;
                    end
                end
            end else begin
                timer_r <= timer_r + TW'(1);
            end
        end else begin
            tx_r <= 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one UART transmitter among NUM_REQ byte streams.
// Optional owner-idle timeout release is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int CLK_HZ         = 83_000_000,
    parameter int BAUD           = 115200,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy,
    output logic                 tx
);

    localparam int DIVISOR = calc_divisor(CLK_HZ, BAUD);
    localparam int IW      = $clog2(NUM_REQ);
    localparam int FCW     = $clog2(FRAME_BITS * DIVISOR + 1);

    if (DIVISOR < 2) begin : g_bad_divisor
        $error("uart_tx_arbiter: CLK_HZ/BAUD must be at least 2");
    end
    if ((NUM_REQ < 2) || (NUM_REQ > 8)) begin : g_bad_num_req
        $error("uart_tx_arbiter: NUM_REQ must be in 2..8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("uart_tx_arbiter: TIMEOUT_CYCLES must be positive");
    end

    arb_state_e         state_r;
    logic [IW-1:0]      ptr_r;
    logic [IW-1:0]      owner_r;
    logic [NUM_REQ-1:0] grant_r;
    logic [FCW-1:0]     frame_cnt_r;
    logic [IW-1:0]      pick_s;
    logic               pick_vld_s;
    logic               ser_ready_s;
    logic               owner_valid_s;
    logic               owner_last_s;
    logic [7:0]         owner_data_s;
    logic               hs_s;
    logic               timeout_s;
    logic               release_s;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] idx);
        if (int'(idx) == NUM_REQ - 1) begin
            return '0;
        end else begin
            return idx + IW'(1);
        end
    endfunction

    // First valid requester at or after ptr, wrapping; scanning downward lets the nearest win.
    always_comb begin
        pick_s     = ptr_r;
        pick_vld_s = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            int idx;
            idx        = (int'(ptr_r) + k) % NUM_REQ;
            pick_s     = req_valid[idx] ? IW'(idx) : pick_s;
            pick_vld_s = pick_vld_s | req_valid[idx];
        end
    end

    assign owner_valid_s = req_valid[owner_r];
    assign owner_last_s  = req_last[owner_r];
    assign owner_data_s  = req_data[8*int'(owner_r) +: 8];
    assign hs_s          = (state_r == ST_LOCK) && owner_valid_s && ser_ready_s;
    assign release_s     = (hs_s && owner_last_s) || timeout_s;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TOW-1:0] idle_cnt_r;
    logic           idle_cyc_s;

    assign idle_cyc_s = (state_r == ST_LOCK) && ser_ready_s && !owner_valid_s;
    assign timeout_s  = idle_cyc_s && (idle_cnt_r == TOW'(TIMEOUT_CYCLES - 1));

    // Consecutive cycles the owner leaves an idle serializer unused.
    always_ff @(posedge clock) begin
        if (reset) begin
            idle_cnt_r <= '0;
        end else if (!idle_cyc_s || timeout_s) begin
            idle_cnt_r <= '0;
        end else begin
            idle_cnt_r <= idle_cnt_r + TOW'(1);
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Arbiter FSM: ownership is held until the packet's last byte or a timeout release.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
            ptr_r   <= '0;
            owner_r <= '0;
            grant_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_vld_s) begin
                        state_r <= ST_LOCK;
                        owner_r <= pick_s;
                        grant_r <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_s;
                    end else begin
                        grant_r <= '0;
                    end
                end
                ST_LOCK: begin
                    if (release_s) begin
                        state_r <= ST_IDLE;
                        ptr_r   <= wrap_inc(owner_r);
                        grant_r <= '0;
                    end else begin
                        state_r <= ST_LOCK;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    grant_r <= '0;
                end
            endcase
        end
    end

    // Mirrors the serializer's frame length so busy covers the final stop cycle too.
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_cnt_r <= '0;
        end else if (hs_s) begin
            frame_cnt_r <= FCW'(FRAME_BITS * DIVISOR);
        end else if (frame_cnt_r != '0) begin
            frame_cnt_r <= frame_cnt_r - FCW'(1);
        end else begin
            frame_cnt_r <= '0;
        end
    end

    assign grant     = grant_r;
    assign req_ready = grant_r & {NUM_REQ{ser_ready_s}};
    assign busy      = (state_r == ST_LOCK) || (frame_cnt_r != '0);

    uart_tx #(
        .DIVISOR (DIVISOR)
    ) u_uart_tx (
        .clock    (clock),
        .reset    (reset),
        .in_valid (hs_s),
        .in_data  (owner_data_s),
        .in_ready (ser_ready_s),
        .tx       (tx)
    );

endmodule
